mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 49 ++++
 rtl/mul_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Requester/response and shared-multiplier signals for mul_arbiter.
// The arbiter connects through the slave modport; requesters and the multiplier sit on the master side.
interface mul_arbiter_if #(
    parameter int unsigned W = 8
);
    logic             req0_valid;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_ready;
    logic             rsp0_valid;
    logic [2*W-1:0]   rsp0_p;
    logic             rsp0_err;

    logic             req1_valid;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_ready;
    logic             rsp1_valid;
    logic [2*W-1:0]   rsp1_p;
    logic             rsp1_err;

    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_done;
    logic [2*W-1:0]   mul_p;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_done, mul_p,
        output req0_ready, rsp0_valid, rsp0_p, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_p, rsp1_err,
        output mul_start, mul_a, mul_b,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_done, mul_p,
        input  req0_ready, rsp0_valid, rsp0_p, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_p, rsp1_err,
        input  mul_start, mul_a, mul_b,
        input  busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter in front of one shared multiplier, with
// a bounded wait for mul_done; one transaction in flight at a time.
module mul_arbiter #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   p_q, p_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             req0_ready;
    logic             req1_ready;
    logic             rsp0_valid;
    logic [2*W-1:0]   rsp0_p;
    logic             rsp0_err;
    logic             rsp1_valid;
    logic [2*W-1:0]   rsp1_p;
    logic             rsp1_err;
    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;

    logic             any_req;
    logic             grant1;

    // Pointer only breaks ties; a lone requester always wins.
    assign any_req = bus.req0_valid | bus.req1_valid;
    assign grant1  = bus.req1_valid & (~bus.req0_valid | ptr_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp0_p     = '0;
        rsp0_err   = 1'b0;
        rsp1_valid = 1'b0;
        rsp1_p     = '0;
        rsp1_err   = 1'b0;
        mul_start  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;

        unique case (state_q)
            IDLE: begin
                // Gated by rst so nothing is handshaken in a cycle the state is being cleared.
                if (any_req && !rst) begin
                    req0_ready = ~grant1;
                    req1_ready = grant1;
                    owner_d    = grant1;
                    a_d        = grant1 ? bus.req1_a : bus.req0_a;
                    b_d        = grant1 ? bus.req1_b : bus.req0_b;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                mul_start = 1'b1;
                mul_a     = a_q;
                mul_b     = b_q;
                cnt_d     = '0;
                state_d   = WAIT;
            end

            WAIT: begin
                mul_a = a_q;
                mul_b = b_q;
                // mul_done takes priority over an expiring counter.
                if (bus.mul_done) begin
                    p_d     = bus.mul_p;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    p_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                if (owner_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_p     = p_q;
                    rsp1_err   = err_q;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_p     = p_q;
                    rsp0_err   = err_q;
                end
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp0_p     = rsp0_p;
    assign bus.rsp0_err   = rsp0_err;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp1_p     = rsp1_p;
    assign bus.rsp1_err   = rsp1_err;
    assign bus.mul_start  = mul_start;
    assign bus.mul_a      = mul_a;
    assign bus.mul_b      = mul_b;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: requester models, a delay-programmable
// multiplier model and a response scoreboard.
module tb_mul_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 63;

    typedef struct {
        logic           owner;
        logic [2*W-1:0] p;
        logic           err;
        logic           to;
    } exp_t;

    logic clk;
    logic rst;

    mul_arbiter_if #(.W(W)) bus ();

    mul_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t           sb[$];
    logic           acc_log[$];
    int             vectors;
    int             miscompares;
    int             cyc;
    int             acc_cyc[2];
    int             last_acc;
    int             start_cyc;
    int             done_cyc;
    int             rsp_cyc[2];
    int             rsp_cnt[2];
    logic [2*W-1:0] last_p;
    logic           last_err;
    logic [W-1:0]   ra[2];
    logic [W-1:0]   rb[2];
    int             rdelay[2];
    int             cur_delay;
    logic [W-1:0]   cur_a;
    logic [W-1:0]   cur_b;

    logic           mdl_done;
    logic [2*W-1:0] mdl_p;
    logic           man_done;

    assign bus.mul_done = mdl_done | man_done;
    assign bus.mul_p    = mdl_done ? mdl_p : 16'hBEEF;

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        sa  = {{W{a[W-1]}}, a};
        sbv = {{W{b[W-1]}}, b};
        return sa * sbv;
    endfunction

    // Multiplier model: mul_done arrives cur_delay cycles after mul_start; delay <= 0 never answers.
    initial begin : mul_model
        int           left;
        logic         pend;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        mdl_done = 1'b0;
        mdl_p    = '0;
        pend     = 1'b0;
        left     = 0;
        ma       = '0;
        mb       = '0;
        forever begin
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
            mdl_p    = '0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    mdl_done = 1'b1;
                    mdl_p    = smul(ma, mb);
                    pend     = 1'b0;
                end
            end
            if (bus.mul_start) begin
                ma   = bus.mul_a;
                mb   = bus.mul_b;
                left = cur_delay;
                pend = (cur_delay > 0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        ra[o]     = a;
        rb[o]     = b;
        rdelay[o] = d;
        if (o) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end
    endtask

    // One clock: sample at negedge, then step input changes to just after the rising edge.
    task automatic tick();
        logic drop0;
        logic drop1;
        drop0 = 1'b0;
        drop1 = 1'b0;
        @(negedge clk);
        cyc++;
        chk("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        if (!bus.rsp0_valid) chk("rsp0_quiet", 32'({bus.rsp0_p, bus.rsp0_err}), 32'd0);
        if (!bus.rsp1_valid) chk("rsp1_quiet", 32'({bus.rsp1_p, bus.rsp1_err}), 32'd0);
        if (!bus.busy) chk("idle_mul", 32'({bus.mul_start, bus.mul_a, bus.mul_b}), 32'd0);

        if (bus.req0_ready || bus.req1_ready) begin
            exp_t e;
            logic o;
            int   d;
            o       = bus.req1_ready;
            d       = rdelay[o];
            e.owner = o;
            e.to    = !(d > 0 && d <= int'(TO));
            e.p     = e.to ? '0 : smul(ra[o], rb[o]);
            e.err   = e.to;
            sb.push_back(e);
            acc_log.push_back(o);
            acc_cyc[o] = cyc;
            last_acc   = cyc;
            cur_delay  = d;
            cur_a      = ra[o];
            cur_b      = rb[o];
            if (o) drop1 = 1'b1; else drop0 = 1'b1;
        end

        if (bus.mul_start) begin
            chk("start_latency", 32'(cyc - last_acc), 32'd1);
            chk("mul_a", 32'(bus.mul_a), 32'(cur_a));
            chk("mul_b", 32'(bus.mul_b), 32'(cur_b));
            start_cyc = cyc;
        end
        if (mdl_done) done_cyc = cyc;

        if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                logic o;
                e = sb.pop_front();
                o = bus.rsp1_valid;
                chk("rsp_owner", 32'({bus.rsp1_valid, bus.rsp0_valid}), e.owner ? 32'd2 : 32'd1);
                last_p   = o ? bus.rsp1_p : bus.rsp0_p;
                last_err = o ? bus.rsp1_err : bus.rsp0_err;
                chk("rsp_p", 32'(last_p), 32'(e.p));
                chk("rsp_err", 32'(last_err), 32'(e.err));
                if (e.to) chk("rsp_lat_timeout", 32'(cyc - start_cyc), 32'(TO + 1));
                else      chk("rsp_lat_done", 32'(cyc - done_cyc), 32'd1);
                rsp_cyc[o] = cyc;
                rsp_cnt[o]++;
            end
        end

        @(posedge clk);
        #1;
        if (drop0) bus.req0_valid = 1'b0;
        if (drop1) bus.req1_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy || bus.req0_valid || bus.req1_valid) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < limit), 32'd1);
    endtask

    initial begin : stim
        int r0;
        int r1;
        vectors        = 0;
        miscompares    = 0;
        cyc            = 0;
        acc_cyc        = '{-1, -1};
        rsp_cyc        = '{-1, -1};
        rsp_cnt        = '{0, 0};
        last_acc       = -100;
        start_cyc      = -100;
        done_cyc       = -100;
        last_p         = '0;
        last_err       = 1'b0;
        cur_delay      = -1;
        cur_a          = '0;
        cur_b          = '0;
        rdelay         = '{-1, -1};
        ra             = '{'0, '0};
        rb             = '{'0, '0};
        man_done       = 1'b0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_outs", 32'({bus.mul_start, bus.req0_ready, bus.req1_ready,
                             bus.rsp0_valid, bus.rsp1_valid}), 32'd0);

        // Single req0 accepted in the first cycle out of reset, 10-cycle multiply
        rst = 1'b0;
        send(1'b0, 8'd13, 8'd28, 10);
        tick();
        chk("first_accept", 32'(acc_cyc[0]), 32'(cyc));
        drain(100);
        chk("p_016C", 32'(last_p), 32'h016C);
        chk("err_0", 32'(last_err), 32'd0);
        chk("rsp0_count", 32'(rsp_cnt[0]), 32'd1);
        chk("rsp1_never", 32'(rsp_cnt[1]), 32'd0);

        // Signed operand on req1
        send(1'b1, 8'hFD, 8'd5, 4);
        drain(100);
        chk("p_FFF1", 32'(last_p), 32'hFFF1);
        chk("err_1", 32'(last_err), 32'd0);

        // Simultaneous requests after reset: req0, then req1, then req0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_log.delete();
        send(1'b0, 8'hF7, 8'h09, 2);
        send(1'b1, 8'h9C, 8'h03, 3);
        drain(200);
        chk("rr_first", 32'(acc_log[0]), 32'd0);
        chk("rr_second", 32'(acc_log[1]), 32'd1);
        chk("rr_gap", 32'(acc_cyc[1] - rsp_cyc[0]), 32'd1);
        send(1'b0, 8'h7F, 8'h80, 1);
        send(1'b1, 8'h80, 8'h80, 1);
        drain(200);
        chk("rr_third", 32'(acc_log[2]), 32'd0);
        chk("rr_fourth", 32'(acc_log[3]), 32'd1);
        chk("min_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        chk("p_4000", 32'(last_p), 32'h4000);

        // Timeout, then recovery
        send(1'b1, 8'd9, 8'd9, -1);
        drain(200);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_p", 32'(last_p), 32'd0);
        send(1'b0, 8'hFF, 8'hFF, 3);
        drain(100);
        chk("after_to_p", 32'(last_p), 32'd1);
        chk("after_to_err", 32'(last_err), 32'd0);

        // Done on the last WAIT cycle wins; one cycle later is a timeout
        send(1'b0, 8'd100, 8'd100, int'(TO));
        drain(200);
        chk("edge_done_err", 32'(last_err), 32'd0);
        chk("edge_done_p", 32'(last_p), 32'h2710);
        send(1'b1, 8'd5, 8'd5, int'(TO) + 1);
        drain(200);
        chk("edge_late_err", 32'(last_err), 32'd1);
        send(1'b0, 8'd2, 8'd3, 1);
        drain(100);
        chk("edge_recover_p", 32'(last_p), 32'd6);

        // Reset three cycles into WAIT; late mul_done must be ignored
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        send(1'b0, 8'd11, 8'd12, -1);
        tick();
        tick();
        repeat (3) tick();
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("rst_wait_busy", 32'(bus.busy), 32'd0);
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (3) tick();
        chk("rst_wait_idle", 32'({bus.busy, bus.mul_start, bus.mul_a, bus.mul_b}), 32'd0);
        chk("rst_wait_norsp", 32'((rsp_cnt[0] - r0) + (rsp_cnt[1] - r1)), 32'd0);

        // mul_done in IDLE with no requests
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (2) tick();
        chk("idle_done_busy", 32'(bus.busy), 32'd0);
        chk("idle_done_norsp", 32'((rsp_cnt[0] - r0) + (rsp_cnt[1] - r1)), 32'd0);

        // A few random operand pairs on alternating requesters
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2), W'($urandom), W'($urandom), int'($urandom_range(1, 12)));
            drain(100);
        end
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
